// File: rtl/load_store_unit.sv
// RV32I memory stage: formats stores, extracts loads, and stalls the pipe until a variable-latency access completes.
// Misaligned or illegal accesses are answered locally with a fault flag and never reach memory.
module load_store_unit #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  state;
  logic [2:0]  op_funct3;
  logic [1:0]  op_off;
  logic        fault;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Address bits above ADDR_WIDTH are deliberately dropped (wrap-around).
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  assign req_ready = (state == S_IDLE);
  assign mem_req   = (state == S_REQ);
  assign rsp_valid = (state == S_RESP);
  assign stall     = ((state == S_IDLE) && req_valid) || (state == S_REQ) || (state == S_WAIT);

  always_comb begin
    fault = 1'b0;
    if (req_we) begin
      fault = (req_funct3 > 3'd2);
    end else begin
      fault = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end
    case (req_funct3)
      3'd1, 3'd5: if (req_addr[0]) fault = 1'b1;
      3'd2:       if (req_addr[1:0] != 2'b00) fault = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = req_wdata;
    case (req_funct3[1:0])
      2'd0: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_be    = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        st_wdata = {2{req_wdata[15:0]}};
        st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!req_we) st_be = 4'b0000;
  end

  assign ld_byte = mem_rdata[{op_off, 3'b000} +: 8];
  assign ld_half = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_data = mem_rdata;
    case (op_funct3)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      op_funct3      <= 3'd0;
      op_off         <= 2'd0;
      rsp_rdata      <= 32'd0;
      rsp_misaligned <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_be         <= 4'b0000;
      mem_wdata      <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_funct3 <= req_funct3;
            op_off    <= req_addr[1:0];
            rsp_rdata <= 32'd0;
            if (fault) begin
              rsp_misaligned <= 1'b1;
              state          <= S_RESP;
            end else begin
              rsp_misaligned <= 1'b0;
              mem_we         <= req_we;
              mem_addr       <= req_addr[ADDR_WIDTH-1:2];
              mem_be         <= st_be;
              mem_wdata      <= st_wdata;
              state          <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // A same-cycle rvalid alongside the grant belongs to nothing we issued.
          if (mem_gnt) state <= mem_we ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            rsp_rdata <= ld_data;
            state     <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drives a cycle-controlled memory responder and checks hand-computed results.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, stall, rsp_valid, rsp_misaligned;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [5:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_WIDTH(8)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_misaligned(rsp_misaligned), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Issues one op at a negedge with the unit idle, then plays memory until rsp_valid.
  // Returns on the RESP cycle; lat counts cycles after acceptance.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gw, input int rw,
                        input logic [31:0] rd, input logic spur, output int lat,
                        output logic saw_req, output logic [5:0] a0, output logic [3:0] be0,
                        output logic [31:0] wd0, output logic we0);
    int g = 0;
    int r = 0;
    logic granted = 1'b0;
    lat = -1; saw_req = 1'b0; a0 = '0; be0 = '0; wd0 = '0; we0 = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    #1;
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    check("accept_stall", {31'd0, stall}, 32'd1);
    @(negedge clock);
    // Garbage on the request bus must be ignored while busy.
    req_valid = 1'b1; req_we = ~we; req_funct3 = 3'd2; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5555_5555;
    for (int c = 1; c <= 40; c++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (rsp_valid) begin
        lat = c;
        break;
      end
      check("busy_stall", {31'd0, stall}, 32'd1);
      check("busy_ready", {31'd0, req_ready}, 32'd0);
      if (mem_req) begin
        if (!saw_req) begin
          saw_req = 1'b1; a0 = mem_addr; be0 = mem_be; wd0 = mem_wdata; we0 = mem_we;
        end else begin
          check("req_stable", {mem_we, mem_be, mem_addr, 21'd0} ^ {we0, be0, a0, 21'd0} ^ (mem_wdata ^ wd0), 32'd0);
        end
        if (g == gw) begin
          mem_gnt = 1'b1; granted = 1'b1;
        end else g++;
        if (spur && c == 1) begin
          mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        end
      end else if (granted && !we) begin
        if (r == rw) begin
          mem_rvalid = 1'b1; mem_rdata = rd;
        end else r++;
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    if (lat < 0) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  // Checks the RESP-cycle results, then steps into the following idle cycle.
  task automatic finish_rsp(input string tag, input int lat, input int exp_lat,
                            input logic [31:0] exp_rdata, input logic exp_mis);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_mis"}, {31'd0, rsp_misaligned}, {31'd0, exp_mis});
    check({tag, "_resp_stall"}, {31'd0, stall}, 32'd0);
    @(negedge clock);
    check({tag, "_pulse_end"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_ready_again"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic saw;
    logic [5:0] a0;
    logic [3:0] be0;
    logic [31:0] wd0;
    logic we0;

    #2;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_bus", {mem_we, mem_be, mem_addr, rsp_misaligned, 20'd0} | mem_wdata | rsp_rdata, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);

    // SW 0xDEADBEEF @0x10, immediate grant
    access(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, 0, 32'd0, 1'b0, lat, saw, a0, be0, wd0, we0);
    check("sw_saw_req", {31'd0, saw}, 32'd1);
    check("sw_addr", {26'd0, a0}, 32'd4);
    check("sw_be", {28'd0, be0}, 32'hF);
    check("sw_wdata", wd0, 32'hDEAD_BEEF);
    check("sw_we", {31'd0, we0}, 32'd1);
    check("sw_req_drop", {31'd0, mem_req}, 32'd0);
    finish_rsp("sw", lat, 2, 32'd0, 1'b0);

    // LB / LBU @0x13, lane 3 = 0x80
    access(1'b0, 3'd0, 32'h13, 32'd0, 0, 0, 32'h80FF_0000, 1'b0, lat, saw, a0, be0, wd0, we0);
    check("lb_addr", {26'd0, a0}, 32'd4);
    check("lb_be", {28'd0, be0}, 32'd0);
    check("lb_we", {31'd0, we0}, 32'd0);
    finish_rsp("lb", lat, 3, 32'hFFFF_FF80, 1'b0);
    access(1'b0, 3'd4, 32'h13, 32'd0, 0, 0, 32'h80FF_0000, 1'b0, lat, saw, a0, be0, wd0, we0);
    finish_rsp("lbu", lat, 3, 32'h0000_0080, 1'b0);

    // SH @0x22 with grant held off 3 cycles
    access(1'b1, 3'd1, 32'h22, 32'h1234_ABCD, 3, 0, 32'd0, 1'b0, lat, saw, a0, be0, wd0, we0);
    check("sh_addr", {26'd0, a0}, 32'd8);
    check("sh_be", {28'd0, be0}, 32'hC);
    check("sh_wdata", wd0, 32'hABCD_ABCD);
    finish_rsp("sh", lat, 5, 32'd0, 1'b0);

    // Faults: LW @0x05, load funct3=3, store funct3=4
    access(1'b0, 3'd2, 32'h05, 32'd0, 0, 0, 32'd0, 1'b0, lat, saw, a0, be0, wd0, we0);
    check("lw_mis_noreq", {31'd0, saw}, 32'd0);
    finish_rsp("lw_mis", lat, 1, 32'd0, 1'b1);
    access(1'b0, 3'd3, 32'h00, 32'd0, 0, 0, 32'd0, 1'b0, lat, saw, a0, be0, wd0, we0);
    check("ld3_noreq", {31'd0, saw}, 32'd0);
    finish_rsp("ld3", lat, 1, 32'd0, 1'b1);
    access(1'b1, 3'd4, 32'h00, 32'h1, 0, 0, 32'd0, 1'b0, lat, saw, a0, be0, wd0, we0);
    check("st4_noreq", {31'd0, saw}, 32'd0);
    finish_rsp("st4", lat, 1, 32'd0, 1'b1);

    // LH @0x02, data 4 cycles after grant, spurious rvalid during REQ
    access(1'b0, 3'd1, 32'h02, 32'd0, 0, 3, 32'h7FFF_0001, 1'b1, lat, saw, a0, be0, wd0, we0);
    finish_rsp("lh", lat, 6, 32'h0000_7FFF, 1'b0);
    // LH sign extension and LHU zero extension
    access(1'b0, 3'd1, 32'h00, 32'd0, 1, 1, 32'h1234_8000, 1'b0, lat, saw, a0, be0, wd0, we0);
    finish_rsp("lh_neg", lat, 5, 32'hFFFF_8000, 1'b0);
    access(1'b0, 3'd5, 32'h06, 32'd0, 0, 0, 32'h8001_0000, 1'b0, lat, saw, a0, be0, wd0, we0);
    finish_rsp("lhu", lat, 3, 32'h0000_8001, 1'b0);
    access(1'b0, 3'd2, 32'h08, 32'd0, 0, 0, 32'hCAFE_F00D, 1'b0, lat, saw, a0, be0, wd0, we0);
    finish_rsp("lw", lat, 3, 32'hCAFE_F00D, 1'b0);

    // SB with address wrap: 0x104 -> word 1, lane 0
    access(1'b1, 3'd0, 32'h104, 32'h0000_00A5, 0, 0, 32'd0, 1'b0, lat, saw, a0, be0, wd0, we0);
    check("sb_wrap_addr", {26'd0, a0}, 32'd1);
    check("sb_be", {28'd0, be0}, 32'h1);
    check("sb_wdata", wd0, 32'hA5A5_A5A5);
    finish_rsp("sb", lat, 2, 32'd0, 1'b0);
    access(1'b1, 3'd0, 32'h0F, 32'h0000_003C, 0, 0, 32'd0, 1'b0, lat, saw, a0, be0, wd0, we0);
    check("sb3_be", {28'd0, be0}, 32'h8);
    finish_rsp("sb3", lat, 2, 32'd0, 1'b0);

    // Reset during WAIT of a load
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h20;
    @(negedge clock);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clock);
    mem_gnt = 1'b0;
    check("wait_stall", {31'd0, stall}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    access(1'b1, 3'd2, 32'h3C, 32'h0BAD_F00D, 0, 0, 32'd0, 1'b0, lat, saw, a0, be0, wd0, we0);
    check("post_rst_addr", {26'd0, a0}, 32'd15);
    check("post_rst_wdata", wd0, 32'h0BAD_F00D);
    finish_rsp("post_rst_sw", lat, 2, 32'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
